connect4_turn_controller: RTL and testbench
===========================================

Name: connect4_turn_controller

Overview:
Sequences one Connect-4 move from a debounced button pulse through the following steps:
- column validation;
- gravity drop (one row scanned per cycle);
- board update;
- a win-check handshake with the winner detector;
- player hand-over.

The block owns the occupancy and owner bitmaps that drive the LED pins and the winner detector. It sits between the button/column front end and the display/detection logic.

Parameters:
ROWS, 4, board rows; row 0 is the bottom row.
COLS, 4, board columns.
CELLS, ROWS*COLS, derived board size; cell index = row*COLS + col.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
btn_pulse  in  1  one-cycle move request from the button press detector.
column_idx  in  2  selected column, 0..COLS-1; width is clog2(COLS).
column_valid  in  1  column_idx is legal (from the column calculator).
new_game  in  1  one-cycle pulse; honoured only in GAME_OVER.
check_done  in  1  winner detector finished; qualifies check_win.
check_win  in  1  the last mover completed four in a row.
check_req  out  1  level request to the winner detector.
gameboard_out  out  CELLS  occupancy bitmap; 1 = cell filled.
player_cells  out  CELLS  owner bitmap; 1 = player 2, valid only where occupied.
current_player  out  1  0 = player 1 to move, 1 = player 2.
game_status  out  2  00 playing, 01 P1 wins, 10 P2 wins, 11 draw.
invalid_move  out  1  one-cycle pulse: move rejected.
busy  out  1  high in every state except IDLE and GAME_OVER.

Behaviour:
- **Reset** (synchronous, active-high, any state including mid-drop or mid-check) produces, on the next edge:
  - state IDLE;
  - gameboard_out=0, player_cells=0;
  - current_player=0, game_status=00;
  - check_req=0, invalid_move=0;
  - move_count=0.
- **States:** IDLE, DROP, WRITE, CHECK, GAME_OVER.
- **IDLE:**
  - btn_pulse=1 and column_valid=1: latch col; row counter r=0; go to DROP.
  - btn_pulse=1 and column_valid=0: invalid_move=1 on the next cycle; stay in IDLE; no board change.
- **DROP:** one row examined per cycle, at cell r*COLS+col.
  - Cell empty: latch target=r; go to WRITE.
  - Cell occupied and r<ROWS-1: r<=r+1.
  - Cell occupied and r==ROWS-1 (column full): invalid_move pulse; return to IDLE; player unchanged.
- **WRITE:** one cycle.
  - gameboard_out[target]<=1.
  - player_cells[target]<=current_player.
  - move_count<=move_count+1.
  - Go to CHECK.
- **CHECK:**
  - check_req=1 from CHECK entry until the cycle check_done=1, inclusive; check_req drops on the next cycle.
  - check_done with check_win=1: game_status<={current_player, ~current_player}; go to GAME_OVER.
  - check_done with check_win=0 and move_count==CELLS: game_status=11; go to GAME_OVER.
  - Otherwise: current_player toggles; go to IDLE.
  - No timeout; the detector must answer.
- **GAME_OVER:**
  - Board and status held.
  - btn_pulse ignored (no invalid_move).
  - new_game clears the board, move_count, current_player and game_status, and goes to IDLE; equivalent to reset.
- **btn_pulse while busy:** ignored, not queued.
- **Latency:** accepted press at cycle t reaches DROP at t+1 and WRITE at t+2+k, where k = number of occupied cells below the target.
  - Board bit visible at t+3+k.
  - check_req asserts at t+3+k.
- **Counters:** move_count has width clog2(CELLS+1) and never wraps, since a full board forces GAME_OVER. r saturates at ROWS-1.
- **Output style:** all outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package connect4_pkg holds:
  - state encoding (IDLE/DROP/WRITE/CHECK/GAME_OVER);
  - game_status codes (ST_PLAYING, ST_P1_WIN, ST_P2_WIN, ST_DRAW);
  - ROWS/COLS defaults;
  - the cell-index function.
- Natural sub-module: connect4_drop_scanner, containing the row counter, column-full detection and target latch, driven by start/col and returning found/full/target. The FSM and board registers stay in the top of this block.

Test Plan:
1. **Basic move.** Reset; press col=2 with a valid column. Expect:
   - DROP at t+1, bit 2 set at t+3;
   - check_req high at t+3;
   - respond check_done=1, check_win=0;
   - current_player=1, state IDLE.
2. **Stacking.** Alternate four presses in col=1, each answered with no win. Expect:
   - bits 1, 5, 9, 13 set;
   - player_cells bits 5 and 13 = 1, bits 1 and 9 = 0;
   - the 4th write occurs 3 cycles later than the 1st.
3. **Column full.** Fifth press in col=1. Expect:
   - invalid_move pulses once after a 4-cycle scan;
   - board unchanged, current_player unchanged, check_req never asserts.
4. **Invalid column.** btn_pulse with column_valid=0. Expect:
   - invalid_move=1 for exactly one cycle;
   - busy stays 0.
5. **Win.** On player 2's move, answer check_win=1. Expect:
   - game_status=10, GAME_OVER;
   - further btn_pulse ignored;
   - new_game clears gameboard_out to 16'h0000 and sets game_status=00.
6. **Draw and mid-operation reset.**
   - Fill all 16 cells with no win: game_status=11 after the 16th check.
   - Separately, assert reset while in CHECK: check_req=0 and the board clears on the next edge.

Source files
------------

// File: rtl/connect4_pkg.sv
// Connect-4 turn controller shared definitions.
// State/status encodings, board defaults and cell indexing.
package connect4_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;

  typedef logic [2:0] state_t;
  typedef logic [1:0] status_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_DROP      = 3'd1;
  localparam state_t S_WRITE     = 3'd2;
  localparam state_t S_CHECK     = 3'd3;
  localparam state_t S_GAME_OVER = 3'd4;

  localparam status_t ST_PLAYING = 2'b00;
  localparam status_t ST_P1_WIN  = 2'b01;
  localparam status_t ST_P2_WIN  = 2'b10;
  localparam status_t ST_DRAW    = 2'b11;

  function automatic int unsigned cell_idx(
    input int unsigned row,
    input int unsigned col,
    input int unsigned ncols
  );
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/connect4_turn_controller_if.sv
// Connect-4 turn controller bus: front end, detector, display.
// master drives the requests, slave is the controller.
interface connect4_turn_controller_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CELLS = ROWS * COLS;
  localparam int CW    = $clog2(COLS);

  logic             btn_pulse;
  logic [CW-1:0]    column_idx;
  logic             column_valid;
  logic             new_game;
  logic             check_done;
  logic             check_win;
  logic             check_req;
  logic [CELLS-1:0] gameboard_out;
  logic [CELLS-1:0] player_cells;
  logic             current_player;
  logic [1:0]       game_status;
  logic             invalid_move;
  logic             busy;

  modport master (
    output btn_pulse, column_idx, column_valid,
    output new_game, check_done, check_win,
    input  check_req, gameboard_out, player_cells,
    input  current_player, game_status,
    input  invalid_move, busy
  );

  modport slave (
    input  btn_pulse, column_idx, column_valid,
    input  new_game, check_done, check_win,
    output check_req, gameboard_out, player_cells,
    output current_player, game_status,
    output invalid_move, busy
  );

endinterface

// File: rtl/connect4_drop_scanner.sv
// Gravity drop scanner: walks a column bottom-up, one row per cycle.
// Reports the first empty row (found) or a full column (full).
module connect4_drop_scanner
  import connect4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic                     scan_i,
  input  logic [$clog2(COLS)-1:0]  col_i,
  input  logic [ROWS*COLS-1:0]     board_i,
  output logic                     found_o,
  output logic                     full_o,
  output logic [$clog2(ROWS)-1:0]  target_o,
  output logic [$clog2(COLS)-1:0]  col_o
);
  localparam int CELLS = ROWS * COLS;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int IW    = $clog2(CELLS);

  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] tgt_q, tgt_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] idx;
  logic          occ;
  logic          last;

  assign idx = IW'(cell_idx(32'(r_q), 32'(col_q), COLS));
  assign occ = board_i[idx];
  assign last = (r_q == RW'(ROWS - 1));

  assign found_o  = scan_i & ~occ;
  assign full_o   = scan_i & occ & last;
  assign target_o = tgt_q;
  assign col_o    = col_q;

  // next row/column/target for the scan in progress
  always_comb begin
    r_d   = r_q;
    tgt_d = tgt_q;
    col_d = col_q;
    if (start_i) begin
      col_d = col_i;
      r_d   = '0;
    end else if (scan_i && occ && !last) begin
      r_d = r_q + 1'b1;
    end
    if (found_o) begin
      tgt_d = r_q;
    end
  end

  // scan registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      tgt_q <= '0;
      col_q <= '0;
    end else begin
      r_q   <= r_d;
      tgt_q <= tgt_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect-4 move sequencer: validate, drop, write, win-check, hand over.
// Owns the occupancy/owner bitmaps; all outputs are registered.
module connect4_turn_controller
  import connect4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input logic                  clk,
  input logic                  reset,
  connect4_turn_controller_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int IW    = $clog2(CELLS);
  localparam int MW    = $clog2(CELLS + 1);

  state_t           state_q, state_d;
  logic [CELLS-1:0] board_q, board_d;
  logic [CELLS-1:0] cells_q, cells_d;
  logic             player_q, player_d;
  status_t          status_q, status_d;
  logic             req_q, req_d;
  logic             inv_q, inv_d;
  logic [MW-1:0]    mc_q, mc_d;

  logic          start;
  logic          scan;
  logic          found;
  logic          full;
  logic [RW-1:0] tgt_row;
  logic [CW-1:0] scan_col;
  logic [IW-1:0] tidx;

  assign start = (state_q == S_IDLE) & bus.btn_pulse & bus.column_valid;
  assign scan  = (state_q == S_DROP);
  assign tidx  = IW'(cell_idx(32'(tgt_row), 32'(scan_col), COLS));

  connect4_drop_scanner #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .scan_i   (scan),
    .col_i    (bus.column_idx),
    .board_i  (board_q),
    .found_o  (found),
    .full_o   (full),
    .target_o (tgt_row),
    .col_o    (scan_col)
  );

  // move sequencing and board update
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    cells_d  = cells_q;
    player_d = player_q;
    status_d = status_q;
    req_d    = req_q;
    inv_d    = 1'b0;
    mc_d     = mc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.btn_pulse) begin
          if (bus.column_valid) begin
            state_d = S_DROP;
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (found) begin
          state_d = S_WRITE;
        end else if (full) begin
          inv_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        board_d[tidx] = 1'b1;
        cells_d[tidx] = player_q;
        mc_d          = mc_q + 1'b1;
        req_d         = 1'b1;
        state_d       = S_CHECK;
      end
      S_CHECK: begin
        if (bus.check_done) begin
          req_d = 1'b0;
          if (bus.check_win) begin
            status_d = {player_q, ~player_q};
            state_d  = S_GAME_OVER;
          end else if (mc_q == MW'(CELLS)) begin
            status_d = ST_DRAW;
            state_d  = S_GAME_OVER;
          end else begin
            player_d = ~player_q;
            state_d  = S_IDLE;
          end
        end
      end
      S_GAME_OVER: begin
        if (bus.new_game) begin
          board_d  = '0;
          cells_d  = '0;
          player_d = 1'b0;
          status_d = ST_PLAYING;
          mc_d     = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // controller state and board registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      cells_q  <= '0;
      player_q <= 1'b0;
      status_q <= ST_PLAYING;
      req_q    <= 1'b0;
      inv_q    <= 1'b0;
      mc_q     <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      cells_q  <= cells_d;
      player_q <= player_d;
      status_q <= status_d;
      req_q    <= req_d;
      inv_q    <= inv_d;
      mc_q     <= mc_d;
    end
  end

  assign bus.check_req      = req_q;
  assign bus.gameboard_out  = board_q;
  assign bus.player_cells   = cells_q;
  assign bus.current_player = player_q;
  assign bus.game_status    = status_q;
  assign bus.invalid_move   = inv_q;
  assign bus.busy = (state_q != S_IDLE) &&
                    (state_q != S_GAME_OVER);

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Bench for connect4_turn_controller: scoreboard + random games.
// Reference model tracks column heights and owners directly.
module tb_connect4_turn_controller;
  import connect4_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CELLS = ROWS * COLS;

  localparam int K_INV = 0;
  localparam int K_REQ = 1;
  localparam int K_END = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  connect4_turn_controller_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  connect4_turn_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         t0;
    int         lat;
    logic [15:0] board;
    logic [15:0] cells;
    logic        player;
    logic [1:0]  status;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          h[COLS];
  logic [15:0] mb;
  logic [15:0] mc;
  logic        mp;
  logic [1:0]  ms;
  int          moves;
  bit          over;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int lat);
    exp_t e;
    e.kind   = kind;
    e.t0     = cyc;
    e.lat    = lat;
    e.board  = mb;
    e.cells  = mc;
    e.player = mp;
    e.status = ms;
    sb.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < COLS; i++) h[i] = 0;
    mb = '0;
    mc = '0;
    mp = 1'b0;
    ms = ST_PLAYING;
    moves = 0;
    over = 1'b0;
  endtask

  // monitor: turns DUT output events into scoreboard pops
  initial begin
    logic pr;
    int   ev;
    exp_t e;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      ev = -1;
      if (bus.invalid_move) ev = K_INV;
      else if (bus.check_req && !pr) ev = K_REQ;
      else if (!bus.check_req && pr) ev = K_END;
      pr = bus.check_req;
      if (ev >= 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", ev, 32'hFF);
        end else begin
          e = sb.pop_front();
          chk("ev_kind", ev, e.kind);
          chk("ev_latency", cyc - e.t0, e.lat);
          chk("ev_board", bus.gameboard_out, e.board);
          chk("ev_cells", bus.player_cells & bus.gameboard_out,
              e.cells & e.board);
          chk("ev_player", bus.current_player, e.player);
          chk("ev_status", bus.game_status, e.status);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    if (over) model_clear();
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic move(input int col, input bit valid, input bit win);
    int k;
    int idx;
    bit rq;
    rq = 1'b0;
    @(negedge clk);
    bus.btn_pulse    = 1'b1;
    bus.column_idx   = col[1:0];
    bus.column_valid = valid;
    if (over) begin
      rq = 1'b0;
    end else if (!valid) begin
      push(K_INV, 1);
    end else if (h[col] == ROWS) begin
      push(K_INV, ROWS + 1);
    end else begin
      k = h[col];
      idx = k * COLS + col;
      mb[idx] = 1'b1;
      mc[idx] = mp;
      h[col]++;
      moves++;
      push(K_REQ, 3 + k);
      rq = 1'b1;
    end
    @(negedge clk);
    bus.btn_pulse    = 1'b0;
    bus.column_valid = 1'b0;
    if (!rq) begin
      repeat (ROWS + 3) @(negedge clk);
      return;
    end
    for (int n = 0; n < 20 && !bus.check_req; n++) @(negedge clk);
    if (!bus.check_req) begin
      chk("req_timeout", bus.check_req, 1);
      return;
    end
    if ($urandom_range(1) == 1) begin
      bus.btn_pulse    = 1'b1;
      bus.column_valid = 1'b1;
      bus.column_idx   = 2'($urandom_range(COLS - 1));
      @(negedge clk);
      bus.btn_pulse    = 1'b0;
      bus.column_valid = 1'b0;
    end
    repeat ($urandom_range(2)) @(negedge clk);
    bus.check_done = 1'b1;
    bus.check_win  = win;
    if (win) begin
      ms = mp ? ST_P2_WIN : ST_P1_WIN;
      over = 1'b1;
    end else if (moves == CELLS) begin
      ms = ST_DRAW;
      over = 1'b1;
    end else begin
      mp = ~mp;
    end
    push(K_END, 1);
    @(negedge clk);
    bus.check_done = 1'b0;
    bus.check_win  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c;
    bus.btn_pulse    = 1'b0;
    bus.column_idx   = '0;
    bus.column_valid = 1'b0;
    bus.new_game     = 1'b0;
    bus.check_done   = 1'b0;
    bus.check_win    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_board", bus.gameboard_out, 0);
    chk("rst_cells", bus.player_cells, 0);
    chk("rst_player", bus.current_player, 0);
    chk("rst_status", bus.game_status, 0);
    chk("rst_req", bus.check_req, 0);
    chk("rst_inv", bus.invalid_move, 0);
    chk("rst_busy", bus.busy, 0);

    move(2, 1, 0);
    chk("t1_player", bus.current_player, 1);
    chk("t1_busy", bus.busy, 0);
    do_new_game();
    chk("t1_newgame_ignored", bus.gameboard_out, mb);

    do_reset();
    for (int i = 0; i < ROWS; i++) move(1, 1, 0);
    chk("t2_board", bus.gameboard_out, 16'h2222);
    chk("t2_cells", bus.player_cells & bus.gameboard_out, 16'h2020);

    move(1, 1, 0);
    chk("t3_board", bus.gameboard_out, 16'h2222);
    chk("t3_player", bus.current_player, 0);

    move(3, 0, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_board", bus.gameboard_out, 16'h2222);

    do_reset();
    move(0, 1, 0);
    move(1, 1, 1);
    chk("t5_status", bus.game_status, 2'b10);
    move(2, 1, 0);
    chk("t5_hold_board", bus.gameboard_out, 16'h0003);
    do_new_game();
    chk("t5_ng_board", bus.gameboard_out, 16'h0000);
    chk("t5_ng_status", bus.game_status, 2'b00);
    chk("t5_ng_player", bus.current_player, 0);

    do_reset();
    for (int i = 0; i < CELLS; i++) begin
      c = $urandom_range(COLS - 1);
      while (h[c] == ROWS) c = (c + 1) % COLS;
      move(c, 1, 0);
    end
    chk("t6_draw", bus.game_status, 2'b11);
    chk("t6_full", bus.gameboard_out, 16'hFFFF);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (over && $urandom_range(1) == 1) begin
        do_new_game();
      end else begin
        move($urandom_range(COLS - 1),
             $urandom_range(9) != 0,
             $urandom_range(7) == 0);
      end
    end

    do_reset();
    @(negedge clk);
    bus.btn_pulse    = 1'b1;
    bus.column_idx   = 2'd0;
    bus.column_valid = 1'b1;
    mb[0] = 1'b1;
    mc[0] = 1'b0;
    push(K_REQ, 3);
    @(negedge clk);
    bus.btn_pulse    = 1'b0;
    bus.column_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.check_req; n++) @(negedge clk);
    chk("t6_req_seen", bus.check_req, 1);
    model_clear();
    push(K_END, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_req", bus.check_req, 0);
    chk("t6_rst_board", bus.gameboard_out, 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
